// File: rtl/vector_cond_unit.sv
// vector_cond_unit: per-lane NZCV condition evaluation and predication for the
// Execute stage of a vector-capable pipeline. Keeps LANES independent flag sets,
// resolves branches from lane 0, and registers condition-qualified controls into M.
// Optional performance counters (ExecCnt/SquashCnt) are built only when
// COND_UNIT_PERF_CNT_EN is defined.
module vector_cond_unit #(
    parameter int LANES  = 4,
    parameter int COND_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COND_W-1:0]    CondE,
    input  logic                 VecE,
    input  logic [LANES*4-1:0]   ALUFlagsE,
    input  logic [1:0]           FlagWriteE,
    input  logic                 RegWriteE,
    input  logic                 MemWriteE,
    input  logic                 PCSrcE,
    input  logic                 BranchE,
    input  logic                 StallE,
    input  logic                 FlushE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 PCSrcM,
    output logic [LANES-1:0]     LaneMaskM,
    output logic                 BranchTakenE,
    output logic [LANES*4-1:0]   FlagsOut
`ifdef COND_UNIT_PERF_CNT_EN
    ,
    output logic [15:0]          ExecCnt,
    output logic [15:0]          SquashCnt
`endif
);

    // Flags packed per lane as {N, Z, C, V}.
    function automatic logic eval_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'b0000: eval_cond = z;
            4'b0001: eval_cond = ~z;
            4'b0010: eval_cond = c;
            4'b0011: eval_cond = ~c;
            4'b0100: eval_cond = n;
            4'b0101: eval_cond = ~n;
            4'b0110: eval_cond = v;
            4'b0111: eval_cond = ~v;
            4'b1000: eval_cond = c & ~z;
            4'b1001: eval_cond = ~(c & ~z);
            4'b1010: eval_cond = (n == v);
            4'b1011: eval_cond = (n != v);
            4'b1100: eval_cond = ~z & (n == v);
            4'b1101: eval_cond = ~(~z & (n == v));
            4'b1110: eval_cond = 1'b1;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    logic [LANES*4-1:0] flags_q, flags_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_write_q, mem_write_d;
    logic               pc_src_q, pc_src_d;
    logic [LANES-1:0]   lane_mask_q, lane_mask_d;

    logic [LANES-1:0]   cond_ex;
    logic [LANES-1:0]   pass;
    logic               valid;
    logic               any_pass;

    // Per-lane condition from pre-update flags, then scalar/vector pass selection.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        cond_ex = '0;
        pass    = '0;
        for (int l = 0; l < LANES; l++) begin
            cond_ex[l] = eval_cond(CondE, flags_q[4*l +: 4]);
        end
        for (int l = 0; l < LANES; l++) begin
            pass[l] = VecE ? cond_ex[l] : cond_ex[0];
        end
    end

    assign valid    = ~StallE & ~FlushE;
    assign any_pass = |pass;

    // Next flags: NZ and CV groups written independently on passing, enabled lanes.
    always_comb begin
        flags_d = flags_q;
        if (valid) begin
            for (int l = 0; l < LANES; l++) begin
                if (pass[l] && (VecE || l == 0)) begin
                    if (FlagWriteE[1]) flags_d[4*l+2 +: 2] = ALUFlagsE[4*l+2 +: 2];
                    if (FlagWriteE[0]) flags_d[4*l   +: 2] = ALUFlagsE[4*l   +: 2];
                end
            end
        end
    end

    // Next M controls: flush clears, stall holds, otherwise qualify by condition.
    always_comb begin
        reg_write_d = reg_write_q;
        mem_write_d = mem_write_q;
        pc_src_d    = pc_src_q;
        lane_mask_d = lane_mask_q;
        if (FlushE) begin
            reg_write_d = 1'b0;
            mem_write_d = 1'b0;
            pc_src_d    = 1'b0;
            lane_mask_d = '0;
        end else if (valid) begin
            reg_write_d = RegWriteE & any_pass;
            mem_write_d = MemWriteE & any_pass;
            pc_src_d    = PCSrcE & cond_ex[0];
            lane_mask_d = pass;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!reset) begin
            flags_q     <= '0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            pc_src_q    <= 1'b0;
            lane_mask_q <= '0;
        end else begin
            flags_q     <= flags_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
            pc_src_q    <= pc_src_d;
            lane_mask_q <= lane_mask_d;
        end
    end

    assign RegWriteM    = reg_write_q;
    assign MemWriteM    = mem_write_q;
    assign PCSrcM       = pc_src_q;
    assign LaneMaskM    = lane_mask_q;
    assign FlagsOut     = flags_q;
    assign BranchTakenE = BranchE & cond_ex[0] & ~FlushE;

`ifdef COND_UNIT_PERF_CNT_EN
    logic [15:0] exec_cnt_q, exec_cnt_d;
    logic [15:0] squash_cnt_q, squash_cnt_d;
    logic        active;

    assign active = valid & (RegWriteE | MemWriteE | PCSrcE | BranchE | (|FlagWriteE));

    // Saturating counters for executed and condition-squashed instructions.
    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (active && any_pass && exec_cnt_q != 16'hFFFF)     exec_cnt_d   = exec_cnt_q + 16'd1;
        if (active && !any_pass && squash_cnt_q != 16'hFFFF)  squash_cnt_d = squash_cnt_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign ExecCnt   = exec_cnt_q;
    assign SquashCnt = squash_cnt_q;
`endif

endmodule
